// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixels to 3x3 interior windows for a Sobel mask; optional macro WINDOW_FRAME_SYNC_EN adds i_sof
module sobel_window_gen #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_valid,
   input  logic [DW-1:0] i_pixel,
`ifdef WINDOW_FRAME_SYNC_EN
   input  logic          i_sof,
`endif
   output logic          o_valid,
   output logic [DW-1:0] o_p0,
   output logic [DW-1:0] o_p1,
   output logic [DW-1:0] o_p2,
   output logic [DW-1:0] o_p3,
   output logic [DW-1:0] o_p5,
   output logic [DW-1:0] o_p6,
   output logic [DW-1:0] o_p7,
   output logic [DW-1:0] o_p8
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d, col;
   logic [RW-1:0] row_q, row_d, row;
   logic          last_col, o_valid_q, o_valid_d;
   logic [DW-1:0] rd0, rd1;
   logic [DW-1:0] lb0 [IMG_W];
   logic [DW-1:0] lb1 [IMG_W];
   logic [DW-1:0] w_q [9];
   logic [DW-1:0] w_d [9];

   // position of the pixel on i_pixel this cycle, start-of-frame forces (0,0)
   always_comb begin
`ifdef WINDOW_FRAME_SYNC_EN
      col = (i_valid && i_sof) ? '0 : col_q;
      row = (i_valid && i_sof) ? '0 : row_q;
`else
      col = col_q;
      row = row_q;
`endif
      last_col = col == CW'(IMG_W - 1);
      col_d = i_valid ? (last_col ? '0 : col + CW'(1)) : col_q;
      row_d = (i_valid && last_col) ? ((row == RW'(IMG_H - 1)) ? '0 : row + RW'(1)) : row_q;
      o_valid_d = i_valid && row >= RW'(2) && col >= CW'(2);
   end

   assign rd0 = lb0[col];
   assign rd1 = lb1[col];

   // line buffers: older line moves down to lb1, new pixel replaces lb0
   always_ff @(posedge clk) begin
      if (i_valid) begin
         lb1[col] <= rd0;
         lb0[col] <= i_pixel;
      end
   end

   // shift every window row left, new right column from line buffers and input
   always_comb begin
      w_d = w_q;
      if (i_valid) begin
         w_d[0] = w_q[1];
         w_d[1] = w_q[2];
         w_d[2] = rd1;
         w_d[3] = w_q[4];
         w_d[4] = w_q[5];
         w_d[5] = rd0;
         w_d[6] = w_q[7];
         w_d[7] = w_q[8];
         w_d[8] = i_pixel;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q     <= '0;
         row_q     <= '0;
         o_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) w_q[i] <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         o_valid_q <= o_valid_d;
         for (int i = 0; i < 9; i++) w_q[i] <= w_d[i];
      end
   end

   assign o_valid = o_valid_q;
   assign o_p0    = w_q[0];
   assign o_p1    = w_q[1];
   assign o_p2    = w_q[2];
   assign o_p3    = w_q[3];
   assign o_p5    = w_q[5];
   assign o_p6    = w_q[6];
   assign o_p7    = w_q[7];
   assign o_p8    = w_q[8];
endmodule
